// File: rtl/spi_v3_loopback_queue_pkg.sv
// Shared types and sizing helpers for the SPI loopback queue.
package spi_v3_loopback_pkg;

    // Transform applied to each packet as it enters the queue.
    typedef enum logic [1:0] {
        LB_ECHO   = 2'b00,
        LB_INVERT = 2'b01,
        LB_INCR   = 2'b10,
        LB_BITREV = 2'b11
    } loopback_mode_e;

    // Pointer width; at least one bit so degenerate depths still elaborate.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spi_v3_loopback_queue_if.sv
// Val/rdy receive and send channels plus mode and occupancy of the loopback queue.
interface spi_v3_loopback_queue_if #(
    parameter int unsigned nbits = 32,
    parameter int unsigned DEPTH = 4
);
    import spi_v3_loopback_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [1:0]       mode;
    logic             recv_val;
    logic             recv_rdy;
    logic [nbits-1:0] recv_msg;
    logic             send_val;
    logic             send_rdy;
    logic [nbits-1:0] send_msg;
    logic [CW-1:0]    count;

    // Upstream/downstream environment side.
    modport master (
        output mode, recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, send_msg, count
    );

    // Queue side.
    modport slave (
        input  mode, recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, send_msg, count
    );

endinterface

// File: rtl/spi_v3_loopback_queue_xform.sv
// Combinational packet transform: echo, invert, increment or bit-reverse.
module spi_v3_loopback_xform
    import spi_v3_loopback_pkg::*;
#(
    parameter int unsigned nbits = 32
) (
    input  logic [1:0]       mode,
    input  logic [nbits-1:0] msg_in,
    output logic [nbits-1:0] msg_out
);

    loopback_mode_e mode_e;
    assign mode_e = loopback_mode_e'(mode);

    // Select the transform; increment wraps naturally at nbits.
    always_comb begin
        msg_out = msg_in;
        unique case (mode_e)
            LB_ECHO:   msg_out = msg_in;
            LB_INVERT: msg_out = ~msg_in;
            LB_INCR:   msg_out = msg_in + {{(nbits-1){1'b0}}, 1'b1};
            LB_BITREV: begin
                for (int i = 0; i < int'(nbits); i++) begin
                    msg_out[i] = msg_in[nbits-1-i];
                end
            end
            default:   msg_out = msg_in;
        endcase
    end

endmodule

// File: rtl/spi_v3_loopback_queue.sv
// Loopback circular queue: packets received on val/rdy are transformed at enqueue and
// returned in FIFO order on the send channel.
// Optional feature macro: SPI_V3_LOOPBACK_BYPASS_EN (zero-latency pass-through when empty).
module spi_v3_loopback_queue
    import spi_v3_loopback_pkg::*;
#(
    parameter int unsigned nbits = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk,
    input logic                    reset,
    spi_v3_loopback_queue_if.slave bus
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [nbits-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic [nbits-1:0] xmsg;
    logic             full, empty;
    logic             enq, deq, bypass;

    spi_v3_loopback_xform #(
        .nbits(nbits)
    ) u_xform (
        .mode   (bus.mode),
        .msg_in (bus.recv_msg),
        .msg_out(xmsg)
    );

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    // Handshake outputs and fire conditions; recv_rdy depends on occupancy only.
    always_comb begin
        bus.recv_rdy = ~full;
        bus.send_val = ~empty;
        bus.send_msg = mem_q[head_q];
        bus.count    = count_q;
        bypass       = 1'b0;
`ifdef SPI_V3_LOOPBACK_BYPASS_EN
        if (empty && bus.recv_val) begin
            bus.send_val = 1'b1;
            bus.send_msg = xmsg;
            // Consumed downstream this cycle, so it never touches storage.
            bypass       = bus.send_rdy;
        end
`endif
        enq = bus.recv_val & ~full & ~bypass;
        deq = ~empty & bus.send_rdy;
    end

    // Occupancy: +1 on enqueue only, -1 on dequeue only.
    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and counter; power-of-two depth lets pointers wrap by overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage write; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= xmsg;
    end

endmodule

// File: tb/tb_spi_v3_loopback_queue.sv
// Scoreboard bench for spi_v3_loopback_queue: directed scenarios plus random traffic.
module tb_spi_v3_loopback_queue;

    localparam int unsigned NB = 32;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    spi_v3_loopback_queue_if #(.nbits(NB), .DEPTH(DP)) ifc ();

    spi_v3_loopback_queue #(.nbits(NB), .DEPTH(DP)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference transform written from the behavioural rules.
    function automatic logic [31:0] model_xf(input logic [1:0] m, input logic [31:0] v);
        logic [31:0] r;
        case (m)
            2'd0: r = v;
            2'd1: r = ~v;
            2'd2: r = v + 32'd1;
            default: r = {<<{v}};
        endcase
        return r;
    endfunction

    // Monitor: check status against model occupancy, then apply handshakes to the model.
    logic exp_val;
    logic [31:0] exp_msg;
    always @(negedge clk) begin
        if (!reset) begin
            exp_val = (sb.size() != 0);
`ifdef SPI_V3_LOOPBACK_BYPASS_EN
            if (sb.size() == 0 && ifc.recv_val) exp_val = 1'b1;
`endif
            chk("count", 32'(ifc.count), 32'(sb.size()));
            chk("recv_rdy", 32'(ifc.recv_rdy), 32'(sb.size() != DP));
            chk("send_val", 32'(ifc.send_val), 32'(exp_val));
            if (ifc.recv_val && sb.size() != DP) sb.push_back(model_xf(ifc.mode, ifc.recv_msg));
            if (exp_val && ifc.send_rdy) begin
                exp_msg = sb.pop_front();
                chk("send_msg", ifc.send_msg, exp_msg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] m, input logic [1:0] md,
                         input logic sr);
        ifc.recv_val = v;
        ifc.recv_msg = m;
        ifc.mode     = md;
        ifc.send_rdy = sr;
        tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        ifc.recv_val = 1'b0;
        ifc.send_rdy = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_send_val", 32'(ifc.send_val), 32'd0);
        chk("rst_count", 32'(ifc.count), 32'd0);
        chk("rst_recv_rdy", 32'(ifc.recv_rdy), 32'd1);
        sb.delete();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        ifc.recv_val = 1'b0;
        ifc.recv_msg = '0;
        ifc.mode     = 2'd0;
        ifc.send_rdy = 1'b0;
        do_reset();
        tick();

        // Fill to full with downstream stalled, then drain in order.
        drive(1'b1, 32'h11, 2'd0, 1'b0);
        drive(1'b1, 32'h22, 2'd0, 1'b0);
        drive(1'b1, 32'h33, 2'd0, 1'b0);
        drive(1'b1, 32'h44, 2'd0, 1'b0);
        drive(1'b0, 32'h0, 2'd0, 1'b0);
        drain(20);

        // Full with simultaneous recv_val and send_rdy: only deq, then enq next cycle.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + i, 2'd0, 1'b0);
        drive(1'b1, 32'h200, 2'd0, 1'b1);
        drive(1'b1, 32'h201, 2'd0, 1'b1);
        drive(1'b1, 32'h202, 2'd0, 1'b1);
        drain(20);

        // Steady state at count 2 with enq+deq every cycle; pointers wrap several times.
        drive(1'b1, 32'h300, 2'd0, 1'b0);
        drive(1'b1, 32'h301, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom, 2'd0, 1'b1);
        drain(20);

        // Transform boundaries with mode switched between entries.
        drive(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0);
        drive(1'b1, 32'h0000_0001, 2'd3, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 2'd0, 1'b0);
        drain(20);
        drive(1'b1, 32'h0000_0001, 2'd2, 1'b0);
        drive(1'b1, 32'h1234_5678, 2'd3, 1'b0);
        drive(1'b1, 32'h0F0F_0F0F, 2'd1, 1'b0);
        drain(20);

        // Reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h400 + i, 2'd0, 1'b0);
        ifc.recv_val = 1'b0;
        do_reset();
        drive(1'b0, 32'h0, 2'd0, 1'b0);
        drive(1'b1, 32'h500, 2'd0, 1'b0);
        drain(20);

        // Empty queue, downstream ready, single packet: bypass or one-cycle latency.
        drive(1'b1, 32'hA5, 2'd0, 1'b1);
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        drive(1'b1, 32'h5A, 2'd2, 1'b0);
        drain(20);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] m;
            case ($urandom_range(0, 3))
                0: m = 32'hFFFF_FFFF;
                1: m = 32'h0000_0001;
                default: m = $urandom;
            endcase
            drive(1'($urandom_range(0, 1)), m, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0));
        end
        drain(50);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
